// File: rtl/dbus_ctrl_pkg.sv
// Shared types and constants for the data-bus controller.
// Used by dbus_ctrl and dbus_io_regs.
package dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_RESP
  } state_e;

  localparam logic [3:0] DEF_IO_BASE_NIB = 4'h1;

  localparam logic [1:0] OFF_GPIO_OUT = 2'd0;
  localparam logic [1:0] OFF_GPIO_IN  = 2'd1;
  localparam logic [1:0] OFF_TIMER    = 2'd2;
  localparam logic [1:0] OFF_CMP      = 2'd3;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/dbus_io_regs.sv
// Local IO register file: GPIO out/in, free-running timer,
// compare register and sticky compare interrupt.
module dbus_io_regs
  import dbus_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        io_we_i,
  input  logic [1:0]  io_off_i,
  input  logic [31:0] io_wdata_i,
  output logic [31:0] io_rdata_o,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq_o
);

  logic [31:0] gpio_q;
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic        wr_gpio;
  logic        wr_timer;
  logic        wr_cmp;

  assign wr_gpio  = io_we_i && (io_off_i == OFF_GPIO_OUT);
  assign wr_timer = io_we_i && (io_off_i == OFF_TIMER);
  assign wr_cmp   = io_we_i && (io_off_i == OFF_CMP);

  // Read mux returns the value held before this edge's update.
  always_comb begin
    io_rdata_o = '0;
    unique case (io_off_i)
      OFF_GPIO_OUT: io_rdata_o = gpio_q;
      OFF_GPIO_IN:  io_rdata_o = gpio_in;
      OFF_TIMER:    io_rdata_o = timer_q;
      OFF_CMP:      io_rdata_o = cmp_q;
    endcase
  end

  // GPIO output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          gpio_q <= '0;
    else if (wr_gpio) gpio_q <= io_wdata_i;
  end

  // Free-running timer; a write replaces that cycle's increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           timer_q <= '0;
    else if (wr_timer) timer_q <= io_wdata_i;
    else               timer_q <= timer_q + 32'd1;
  end

  // Compare register and sticky irq; a CMP write beats a match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= '0;
      irq_q <= 1'b0;
    end else if (wr_cmp) begin
      cmp_q <= io_wdata_i;
      irq_q <= 1'b0;
    end else if (timer_q == cmp_q) begin
      irq_q <= 1'b1;
    end
  end

  assign gpio_out = gpio_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/dbus_ctrl.sv
// Load/store bus controller: routes core accesses to external
// RAM (ack handshake with timeout) or the local IO registers.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int         TIMEOUT     = 16,
  parameter logic [3:0] IO_BASE_NIB = DEF_IO_BASE_NIB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  input  logic        ram_ack_i,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        irq_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          stall_q;
  logic          err_q;
  logic          eflag_q;
  logic          ram_req_q;
  logic          ram_we_q;
  logic [31:0]   ram_addr_q;
  logic [31:0]   ram_wdata_q;
  logic          is_io;
  logic          io_we;
  logic [31:0]   io_rdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // IO decode happens straight off the request while idle.
  assign is_io = addr_i[31:28] == IO_BASE_NIB;
  assign io_we = (state_q == ST_IDLE) && req_i && is_io && we_i;

  dbus_io_regs u_io (
    .clk        (clk),
    .rst        (rst),
    .io_we_i    (io_we),
    .io_off_i   (addr_i[3:2]),
    .io_wdata_i (wdata_i),
    .io_rdata_o (io_rdata),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .irq_o      (irq_o)
  );

  // Access FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
      eflag_q     <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            ram_addr_q  <= {addr_i[31:2], 2'b00};
            ram_we_q    <= we_i;
            ram_wdata_q <= wdata_i;
            eflag_q     <= 1'b0;
            stall_q     <= 1'b1;
            if (is_io) begin
              rdata_q <= we_i ? 32'h0 : io_rdata;
              state_q <= ST_RESP;
            end else begin
              ram_req_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ST_RAM_WAIT;
            end
          end
        end
        ST_RAM_WAIT: begin
          if (ram_ack_i) begin
            rdata_q   <= ram_we_q ? 32'h0 : ram_rdata_i;
            ram_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q   <= ERR_RDATA;
            eflag_q   <= 1'b1;
            ram_req_q <= 1'b0;
            state_q   <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          err_q   <= eflag_q;
          stall_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o     = rdata_q;
  assign ready_o     = ready_q;
  assign stall_o     = stall_q;
  assign err_o       = err_q;
  assign ram_req_o   = ram_req_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: directed literal cases followed by random
// traffic checked every cycle against a transaction-level model.
module tb_dbus_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        stall_o;
  logic        err_o;
  logic        ram_req_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;
  logic        ram_ack_i = 1'b0;
  logic [31:0] gpio_in = '0;
  logic [31:0] gpio_out;
  logic        irq_o;

  int n_chk = 0;
  int n_fail = 0;

  dbus_ctrl #(.TIMEOUT(TMO), .IO_BASE_NIB(4'h1)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .ready_o     (ready_o),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .ram_req_o   (ram_req_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_ack_i   (ram_ack_i),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_ph: 0 no access, 1 waiting on RAM, 2 completing next edge
  int          m_ph = 0;
  int          m_cnt = 0;
  logic [31:0] m_timer = '0, m_cmp = '0, m_gpio = '0;
  logic [31:0] m_rdata = '0, m_addr = '0, m_wdata = '0;
  logic        m_irq = 0, m_we = 0, m_ready = 0, m_err = 0;
  logic        m_eflag = 0;

  initial forever begin
    logic [31:0] ot, oc, rd, wd;
    logic        iw;
    logic [1:0]  off;
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_cnt = 0; m_timer = 0; m_cmp = 0; m_gpio = 0;
      m_rdata = 0; m_addr = 0; m_wdata = 0; m_irq = 0; m_we = 0;
      m_ready = 0; m_err = 0; m_eflag = 0;
    end else begin
      ot = m_timer; oc = m_cmp; iw = 0; off = 0; wd = 0;
      m_ready = 0; m_err = 0;
      if (m_ph == 2) begin
        m_ready = 1; m_err = m_eflag; m_ph = 0;
      end else if (m_ph == 1) begin
        if (ram_ack_i) begin
          m_rdata = m_we ? 32'h0 : ram_rdata_i; m_ph = 2;
        end else if (m_cnt == TMO - 1) begin
          m_rdata = 0; m_eflag = 1; m_ph = 2;
        end else m_cnt++;
      end else if (req_i) begin
        m_addr = {addr_i[31:2], 2'b00}; m_we = we_i;
        m_wdata = wdata_i; m_eflag = 0;
        if (addr_i[31:28] == 4'h1) begin
          off = addr_i[3:2];
          rd = (off == 0) ? m_gpio : (off == 1) ? gpio_in :
               (off == 2) ? ot : oc;
          m_rdata = we_i ? 32'h0 : rd;
          iw = we_i; wd = wdata_i; m_ph = 2;
        end else begin
          m_ph = 1; m_cnt = 0;
        end
      end
      m_timer = (iw && off == 2) ? wd : ot + 1;
      if (iw && off == 3) begin m_cmp = wd; m_irq = 0; end
      else if (ot == oc) m_irq = 1;
      if (iw && off == 0) m_gpio = wd;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("stall", stall_o, m_ph != 0);
      chk("ready", ready_o, m_ready);
      chk("err", err_o, m_err);
      chk("ram_req", ram_req_o, m_ph == 1);
      chk("gpio_out", gpio_out, m_gpio);
      chk("irq", irq_o, m_irq);
      if (m_ph == 1) begin
        chk("ram_addr", ram_addr_o, m_addr);
        chk("ram_we", ram_we_o, m_we);
        chk("ram_wdata", ram_wdata_o, m_wdata);
      end
      if (m_ready && !(m_we && m_addr[31:28] == 4'h1))
        chk("rdata", rdata_o, m_rdata);
    end
  end

  // ---------------- RAM responder ----------------
  int          force_lat = -1;
  int          cur_lat = 0;
  int          wcnt = 0;
  logic [31:0] ack_data = '0;

  initial forever begin
    int r;
    @(negedge clk);
    if (!ram_req_o) begin
      wcnt = 0; ram_ack_i = 0; ram_rdata_i = $urandom();
    end else begin
      if (wcnt == 0) begin
        if (force_lat >= 0) cur_lat = force_lat;
        else begin
          r = $urandom_range(0, 9);
          if (r < 6)       cur_lat = $urandom_range(0, 6);
          else if (r == 6) cur_lat = TMO - 1;
          else if (r == 7) cur_lat = TMO;
          else             cur_lat = $urandom_range(0, 25);
        end
      end
      ram_ack_i = (wcnt == cur_lat);
      ram_rdata_i = (force_lat >= 0) ? ack_data : $urandom();
      wcnt++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic io_access(input logic w, input logic [1:0] o,
                           input logic [31:0] d,
                           output logic [31:0] rd, output int lat);
    @(negedge clk);
    req_i = 1; we_i = w; addr_i = {4'h1, 24'h0, o, 2'b00}; wdata_i = d;
    @(posedge clk); #1;
    chk("io_stall", stall_o, 1);
    @(negedge clk); req_i = 0;
    lat = 0; rd = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready_o) begin lat = i; rd = rdata_o; break; end
    end
  endtask

  task automatic ram_access(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input int l,
                            input bit pulse, output logic [31:0] rd,
                            output int rc, output logic e,
                            output int nrdy);
    force_lat = l; ack_data = d;
    @(negedge clk);
    req_i = 1; we_i = w; addr_i = a; wdata_i = d;
    @(posedge clk);
    rc = 0; nrdy = 0; rd = '0; e = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      req_i = pulse && (i == 1);
      if (ram_req_o) rc++;
      @(posedge clk); #1;
      if (ready_o) begin nrdy = 1; rd = rdata_o; e = err_o; break; end
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (ready_o) nrdy++;
    end
    force_lat = -1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd, a;
    int          lat, rc, nr, n;
    logic        e;
    logic [1:0]  off;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ram_req", ram_req_o, 0);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_ram_addr", ram_addr_o, 0);
    @(negedge clk); rst = 0;

    io_access(1, 2'd0, 32'hA5A5_0001, rd, lat);
    chk("io_store_lat", lat, 1);
    chk("io_store_gpio", gpio_out, 32'hA5A5_0001);

    ram_access(0, 32'h0000_0040, 32'h1234_5678, 2, 0, rd, rc, e, nr);
    chk("ram_ld_cycles", rc, 3);
    chk("ram_ld_data", rd, 32'h1234_5678);
    chk("ram_ld_err", e, 0);
    chk("ram_ld_nrdy", nr, 1);

    ram_access(0, 32'h0000_0100, 32'h0BAD_0BAD, 1000, 0, rd, rc, e, nr);
    chk("tmo_cycles", rc, TMO);
    chk("tmo_err", e, 1);
    chk("tmo_data", rd, 0);
    chk("tmo_nrdy", nr, 1);

    ram_access(0, 32'h2000_0008, 32'hCAFE_F00D, 5, 1, rd, rc, e, nr);
    chk("pulse_nrdy", nr, 1);
    chk("pulse_data", rd, 32'hCAFE_F00D);
    chk("pulse_cycles", rc, 6);

    ram_access(1, 32'h0000_0086, 32'h0000_55AA, 0, 0, rd, rc, e, nr);
    chk("st_cycles", rc, 1);
    chk("st_rdata", rd, 0);

    gpio_in = 32'hDEAD_0000;
    io_access(0, 2'd1, 0, rd, lat);
    chk("gpin_rd", rd, 32'hDEAD_0000);
    io_access(1, 2'd1, 32'h0000_1234, rd, lat);
    chk("gpin_wr_gpio", gpio_out, 32'hA5A5_0001);
    io_access(0, 2'd1, 0, rd, lat);
    chk("gpin_rd2", rd, 32'hDEAD_0000);
    io_access(0, 2'd0, 0, rd, lat);
    chk("gpout_rd", rd, 32'hA5A5_0001);

    io_access(1, 2'd3, 32'd20, rd, lat);
    chk("cmp_clr", irq_o, 0);
    io_access(1, 2'd2, 32'd0, rd, lat);
    chk("irq_early", irq_o, 0);
    n = 0;
    for (int i = 2; i <= 40; i++) begin
      @(posedge clk); #1;
      if (irq_o) begin n = i; break; end
    end
    chk("irq_rise_edge", n, 21);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_sticky", irq_o, 1);
    io_access(1, 2'd3, 32'h0000_FFFF, rd, lat);
    chk("irq_cleared", irq_o, 0);
    io_access(1, 2'd2, 32'hFFFF_FFFF, rd, lat);
    io_access(0, 2'd2, 0, rd, lat);
    chk("timer_wrap", rd, 0);
    io_access(0, 2'd3, 0, rd, lat);
    chk("cmp_rd", rd, 32'h0000_FFFF);

    force_lat = 1000;
    @(negedge clk);
    req_i = 1; we_i = 0; addr_i = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk); req_i = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("rst_mid_req", ram_req_o, 0);
    chk("rst_mid_stall", stall_o, 0);
    @(negedge clk);
    #2 rst = 0;
    force_lat = -1;
    nr = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ready_o) nr++;
    end
    chk("rst_mid_nrdy", nr, 0);

    repeat (3000) begin
      @(negedge clk);
      gpio_in = $urandom();
      req_i = ($urandom_range(0, 2) == 0);
      we_i = $urandom_range(0, 1);
      off = 2'($urandom_range(0, 3));
      a = $urandom();
      if ($urandom_range(0, 1) == 0) a[31:28] = 4'h1;
      a[3:2] = off;
      addr_i = a;
      if (off == 2'd3 && $urandom_range(0, 1) == 1)
        wdata_i = m_timer + $urandom_range(3, 40);
      else if (off == 2'd2 && $urandom_range(0, 7) == 0)
        wdata_i = 32'hFFFF_FFFF;
      else
        wdata_i = $urandom();
    end
    @(negedge clk); req_i = 0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
